// File: rtl/alu_result_queue.sv
// rtl/alu_result_queue.sv - registered, flag-annotating result FIFO behind the 8-operation ALU
module alu_result_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_y,
    input  logic                     in_cout,
    input  logic [2:0]               in_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_y,
    output logic [2:0]               out_sel,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic                     out_carry,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CW-1:0]            acc_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 22;
    localparam logic [2:0] SEL_ADD = 3'd4;
    localparam logic [2:0] SEL_MUL = 3'd6;

    // Entry layout: {sel[21:19], zero[18], neg[17], carry[16], y[15:0]}
    logic [EW-1:0]  mem_q [DEPTH];
    logic [EW-1:0]  mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic [CW-1:0]  acc_q, acc_d;

    logic           push, pop;
    logic [15:0]    masked_y;
    logic           new_zero, new_neg, new_carry;
    logic [EW-1:0]  new_entry;
    logic [EW-1:0]  head;

    assign in_ready  = (count_q < (AW + 1)'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Only MUL drives the upper byte; all other ALU paths leave it undriven.
    always_comb begin
        masked_y  = (in_sel == SEL_MUL) ? in_y : {8'h00, in_y[7:0]};
        new_zero  = (masked_y == 16'h0000);
        new_neg   = (in_sel == SEL_MUL) ? masked_y[15] : masked_y[7];
        new_carry = (in_sel == SEL_ADD) ? in_cout : 1'b0;
        new_entry = {in_sel, new_zero, new_neg, new_carry, masked_y};
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        acc_d    = acc_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = new_entry;
                wr_ptr_d        = wr_ptr_q + 1'b1;
                if (acc_q != {CW{1'b1}}) begin
                    acc_d = acc_q + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            acc_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
        end
    end

    // Storage needs no reset: reads are gated by out_valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head      = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_sel   = head[21:19];
    assign out_zero  = head[18];
    assign out_neg   = head[17];
    assign out_carry = head[16];
    assign out_y     = head[15:0];
    assign count     = count_q;
    assign acc_count = acc_q;

endmodule

// File: tb/tb_alu_result_queue.sv
// tb/tb_alu_result_queue.sv - vector table plus scoreboard bench for alu_result_queue
module tb_alu_result_queue;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_cout, out_ready;
    logic [15:0] in_y;
    logic [2:0]  in_sel;
    logic        in_ready, out_valid, out_zero, out_neg, out_carry;
    logic [15:0] out_y;
    logic [2:0]  out_sel;
    logic [2:0]  count;
    logic [7:0]  acc_count;

    int tests = 0;
    int fails = 0;

    alu_result_queue #(.DEPTH(4), .CW(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y),
        .in_cout(in_cout), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_sel(out_sel), .out_zero(out_zero), .out_neg(out_neg),
        .out_carry(out_carry), .count(count), .acc_count(acc_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] y;
        logic [2:0]  sel;
        logic        z;
        logic        n;
        logic        c;
    } exp_t;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] y;
        logic        cout;
        exp_t        exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic exp_t model(logic [2:0] sel, logic [15:0] y, logic cout);
        exp_t e;
        e.y   = (sel == 3'd6) ? y : {8'h00, y[7:0]};
        e.sel = sel;
        e.z   = (e.y == 16'h0000);
        e.n   = (sel == 3'd6) ? e.y[15] : e.y[7];
        e.c   = (sel == 3'd4) ? cout : 1'b0;
        return e;
    endfunction

    // Scoreboard: expected entries queued on push, compared on pop.
    always @(negedge clk) begin
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    check("sb_head", 32'({out_y, out_sel, out_zero, out_neg, out_carry}), 32'(sb[0]));
                    void'(sb.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(in_sel, in_y, in_cout));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [2:0] sel, logic [15:0] y, logic c);
        in_valid = v;
        in_sel   = sel;
        in_y     = y;
        in_cout  = c;
    endtask

    task automatic drive_rand();
        drive(1'b1, 3'($urandom_range(0, 7)), 16'($urandom), 1'($urandom));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic check_idle(string name);
        check({name, "_out"}, 32'({out_valid, out_y, out_sel, out_zero, out_neg, out_carry}), 32'd0);
        check({name, "_rdy_cnt"}, 32'({in_ready, count}), 32'({1'b1, 3'd0}));
    endtask

    initial begin
        logic [15:0] held_y;
        vecs[0] = '{3'd4, 16'hA52A, 1'b1, '{16'h002A, 3'd4, 1'b0, 1'b0, 1'b1}};
        vecs[1] = '{3'd6, 16'hFE01, 1'b1, '{16'hFE01, 3'd6, 1'b0, 1'b1, 1'b0}};
        vecs[2] = '{3'd4, 16'h0000, 1'b1, '{16'h0000, 3'd4, 1'b1, 1'b0, 1'b1}};
        vecs[3] = '{3'd5, 16'h3380, 1'b1, '{16'h0080, 3'd5, 1'b0, 1'b1, 1'b0}};
        vecs[4] = '{3'd0, 16'hFF00, 1'b0, '{16'h0000, 3'd0, 1'b1, 1'b0, 1'b0}};
        vecs[5] = '{3'd6, 16'h0000, 1'b1, '{16'h0000, 3'd6, 1'b1, 1'b0, 1'b0}};
        vecs[6] = '{3'd7, 16'h12FF, 1'b1, '{16'h00FF, 3'd7, 1'b0, 1'b1, 1'b0}};
        vecs[7] = '{3'd3, 16'h7F7F, 1'b0, '{16'h007F, 3'd3, 1'b0, 1'b0, 1'b0}};

        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 3'd0, 16'h0000, 1'b0);
        step();
        step();
        rst = 1'b0;
        check_idle("reset");
        check("reset_acc", 32'(acc_count), 32'd0);

        // Single-entry vectors: push into empty queue, inspect head, pop.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vecs[i].sel, vecs[i].y, vecs[i].cout);
            step();
            drive(1'b0, 3'd0, 16'h0000, 1'b0);
            check($sformatf("vec%0d_head", i),
                  32'({out_valid, out_y, out_sel, out_zero, out_neg, out_carry}),
                  32'({1'b1, vecs[i].exp}));
            check($sformatf("vec%0d_count", i), 32'(count), 32'd1);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check($sformatf("vec%0d_drained", i), 32'({out_valid, count}), 32'd0);
        end
        check("vec_acc", 32'(acc_count), 32'd8);

        // Fill to DEPTH with MUL then ADD at the head; a fifth offer is refused.
        drive(1'b1, 3'd6, 16'hFE01, 1'b0); step();
        drive(1'b1, 3'd4, 16'h0000, 1'b1); step();
        drive_rand(); step();
        drive_rand(); step();
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        held_y = out_y;
        drive_rand(); step();
        drive(1'b0, 3'd0, 16'h0000, 1'b0);
        check("full_acc_hold", 32'(acc_count), 32'd12);
        check("full_head_stable", 32'(out_y), 32'(held_y));
        check("full_head_mul", 32'({out_y, out_neg, out_carry}), 32'({16'hFE01, 1'b1, 1'b0}));
        out_ready = 1'b1;
        step();
        check("second_head_add", 32'({out_y, out_zero, out_carry}), 32'({16'h0000, 1'b1, 1'b1}));
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b0;
        check("drain_empty", 32'({out_valid, count}), 32'd0);

        // Full queue with simultaneous offer and pop: pop only.
        for (int i = 0; i < 4; i++) begin drive_rand(); step(); end
        out_ready = 1'b1;
        step();
        check("full_pop_no_push", 32'(count), 32'd3);
        step();
        check("pushpop_count", 32'(count), 32'd3);
        drive(1'b0, 3'd0, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b0;
        check("pushpop_drained", 32'(count), 32'd0);

        // Steady stream from reset.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_rand();
            step();
            check($sformatf("stream%0d_count", i), 32'(count), 32'd1);
        end
        drive(1'b0, 3'd0, 16'h0000, 1'b0);
        step();
        out_ready = 1'b0;
        check("stream_acc", 32'(acc_count), 32'd20);
        check("stream_empty", 32'(count), 32'd0);

        // Flush drops the concurrent push and keeps acc_count.
        do_reset();
        for (int i = 0; i < 3; i++) begin drive_rand(); step(); end
        flush = 1'b1;
        drive_rand();
        step();
        flush = 1'b0;
        drive(1'b0, 3'd0, 16'h0000, 1'b0);
        check("flush_state", 32'({out_valid, count}), 32'd0);
        check("flush_acc", 32'(acc_count), 32'd3);

        // Saturation of the accepted-push counter, then reset mid-stream.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin drive_rand(); step(); end
        check("acc_saturate", 32'(acc_count), 32'd255);
        check("sat_count", 32'(count), 32'd1);
        rst = 1'b1;
        drive_rand();
        step();
        rst = 1'b0;
        drive(1'b0, 3'd0, 16'h0000, 1'b0);
        out_ready = 1'b0;
        check_idle("midrst");
        check("midrst_acc", 32'(acc_count), 32'd0);

        step();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
